// File: rtl/alu_result_framer.sv
// alu_result_framer: serialises an ALU result word and its {V,C,N,Z,P} flags into a UART byte frame
//   Frame: SYNC_BYTE, {3'b000,flags}, result bytes MSB first, and optionally CSUM
//   (XOR of the flags byte and all result bytes) when ALU_FRAMER_CSUM_EN is defined.
//   Ports:
//     clk, rst_n           clock, synchronous active-low reset
//     in_valid/in_ready    result/flags capture handshake (ready only while idle)
//     in_result[N-1:0]     ALU result
//     in_flags[4:0]        {V,C,N,Z,P}
//     tx_data/tx_valid     registered byte stream toward the UART transmitter
//     tx_ready             byte accepted when tx_valid && tx_ready
//     busy                 frame in progress
module alu_result_framer #(
    parameter int          N         = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_result,
    input  logic [4:0]   in_flags,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy
);
    localparam int NB = N / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        FLAGS,
`ifdef ALU_FRAMER_CSUM_EN
        DATA,
        CSUM
`else
        DATA
`endif
    } state_t;

    state_t         state, nx_state;
    logic [IW-1:0]  idx, nx_idx, data_idx;
    logic [N-1:0]   res, res_sh;
    logic [4:0]     flg;
    logic [7:0]     nx_data, res_byte;
    logic           nx_valid, accept, last;

    assign accept   = tx_valid && tx_ready;
    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;
    assign last     = idx == IW'(NB - 1);
    // Byte to present next: byte 0 when leaving FLAGS, idx+1 while walking DATA
    assign data_idx = (state == DATA) ? idx + 1'b1 : '0;
    assign res_sh   = res << {data_idx, 3'b000};
    assign res_byte = res_sh[N-1 -: 8];

`ifdef ALU_FRAMER_CSUM_EN
    logic [7:0] csum, in_csum;
    always_comb begin
        in_csum = {3'b000, in_flags};
        for (int i = 0; i < NB; i++)
            in_csum = in_csum ^ in_result[8*i +: 8];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            res      <= '0;
            flg      <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
`ifdef ALU_FRAMER_CSUM_EN
            csum     <= 8'h00;
`endif
        end else begin
            state    <= nx_state;
            idx      <= nx_idx;
            tx_data  <= nx_data;
            tx_valid <= nx_valid;
            if (in_valid && in_ready) begin
                res <= in_result;
                flg <= in_flags;
`ifdef ALU_FRAMER_CSUM_EN
                csum <= in_csum;
`endif
            end
        end
    end

    always_comb begin
        nx_state = state;
        nx_idx   = idx;
        nx_data  = tx_data;
        nx_valid = tx_valid;
        case (state)
            IDLE: if (in_valid) begin
                nx_state = SYNC;
                nx_data  = SYNC_BYTE;
                nx_valid = 1'b1;
            end
            SYNC: if (accept) begin
                nx_state = FLAGS;
                nx_data  = {3'b000, flg};
            end
            FLAGS: if (accept) begin
                nx_state = DATA;
                nx_idx   = '0;
                nx_data  = res_byte;
            end
            DATA: if (accept) begin
                if (last) begin
`ifdef ALU_FRAMER_CSUM_EN
                    nx_state = CSUM;
                    nx_data  = csum;
`else
                    nx_state = IDLE;
                    nx_data  = 8'h00;
                    nx_valid = 1'b0;
`endif
                end else begin
                    nx_idx  = idx + 1'b1;
                    nx_data = res_byte;
                end
            end
`ifdef ALU_FRAMER_CSUM_EN
            CSUM: if (accept) begin
                nx_state = IDLE;
                nx_data  = 8'h00;
                nx_valid = 1'b0;
            end
`endif
            default: begin
                nx_state = IDLE;
                nx_valid = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_alu_result_framer.sv
// tb_alu_result_framer: directed and random frames checked against a frame-list reference model
module tb_alu_result_framer;
    localparam int N  = 16;
    localparam int NB = N / 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_result;
    logic [4:0]   in_flags;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    int           checks = 0;
    int           failures = 0;

    alu_result_framer #(.N(N), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the framer idle; returns at the negedge after the frame.
    // mode: 0 ready always high, 1 random ready, 2 ready low 3 cycles while FLAGS is shown.
    // rst_at >= 0 pulses reset once that many bytes have been accepted.
    task automatic run_frame(input logic [N-1:0] r, input logic [4:0] f, input int mode,
                             input int rst_at, input logic hold,
                             input logic [N-1:0] nr, input logic [4:0] nf);
        logic [7:0] q[$];
        logic [7:0] cs, v;
        logic       rdy;
        int         idx = 0;
        int         stall = 0;
        q.push_back(8'hA5);
        q.push_back({3'b000, f});
        cs = {3'b000, f};
        for (int b = 0; b < NB; b++) begin
            v = 8'(r >> (8 * (NB - 1 - b)));
            q.push_back(v);
            cs = cs ^ v;
        end
`ifdef ALU_FRAMER_CSUM_EN
        q.push_back(cs);
`endif
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_result = r;
        in_flags  = f;
        tx_ready  = 1'($urandom);
        @(negedge clk);
        in_valid  = hold;
        in_result = nr;
        in_flags  = nf;
        for (int cyc = 0; cyc < 200 && idx < q.size(); cyc++) begin
            if (idx == rst_at) break;
            chk("tx_valid", 32'(tx_valid), 32'd1);
            chk($sformatf("byte%0d", idx), 32'(tx_data), 32'(q[idx]));
            chk("busy", 32'(busy), 32'd1);
            if (hold) chk("in_ready_busy", 32'(in_ready), 32'd0);
            rdy = (mode == 0) ? 1'b1 :
                  (mode == 1) ? ($urandom_range(0, 3) != 0) :
                  !(idx == 1 && stall < 3);
            if (!rdy) stall++;
            tx_ready = rdy;
            @(negedge clk);
            if (rdy) idx++;
        end
        if (rst_at >= 0) begin
            chk("reached_reset_point", 32'(idx), 32'(rst_at));
            rst_n    = 1'b0;
            tx_ready = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
            chk("rst_tx_valid", 32'(tx_valid), 32'd0);
            chk("rst_tx_data", 32'(tx_data), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk("rst_no_more_bytes", 32'(tx_valid), 32'd0);
            end
            return;
        end
        chk("frame_len", 32'(idx), 32'(q.size()));
        chk("end_tx_valid", 32'(tx_valid), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_flags  = '0;
        tx_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_tx_valid", 32'(tx_valid), 32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(16'h9C40, 5'b10100, 0, -1, 1'b0, '0, '0);
        run_frame(16'h0000, 5'b00011, 0, -1, 1'b0, '0, '0);
        run_frame(16'h9C40, 5'b10100, 2, -1, 1'b0, '0, '0);
        run_frame(16'h9C40, 5'b10100, 0, -1, 1'b1, 16'h1234, 5'b00001);
        run_frame(16'h1234, 5'b00001, 0, -1, 1'b0, '0, '0);
        run_frame(16'h9C40, 5'b10100, 0, 3, 1'b0, '0, '0);
        for (int i = 0; i < 20; i++)
            run_frame(N'($urandom), 5'($urandom), 1, -1, 1'b0, '0, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_result_framer.md
Name: alu_result_framer

Overview:
- Output-side partner of the ALU datapath: accepts one ALU result word plus its 5-bit flag vector {V,C,N,Z,P} over a valid/ready handshake.
- Serialises the pair into a byte frame for the UART transmitter over a byte-wide valid/ready handshake.
- Sits between the ALU result stage and the UART TX byte interface.

Parameters:
- N, 16, result width in bits; legal values 8, 16, 24, 32 (multiple of 8).
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  result/flags word offered.
- in_ready  out  1  framer can capture a word (high only in IDLE).
- in_result  in  N  ALU result, two's complement.
- in_flags  in  5  {V,C,N,Z,P}.
- tx_data  out  8  current frame byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts byte.
- busy  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, tx_valid=0, tx_data=8'h00, busy=0, in_ready=1.
  - Capture registers and checksum are cleared.
  - Reset mid-frame abandons the frame; no further bytes are emitted.
- Capture:
  - On the edge where in_valid && in_ready, latch in_result and in_flags.
  - in_valid while not in IDLE is ignored; the word is not consumed.
- Frame is SYNC, FLAGS, RES[N/8 bytes, MSB first], CSUM.
  - FLAGS = {3'b000, V, C, N, Z, P}.
  - CSUM = XOR of FLAGS and all RES bytes; SYNC is excluded.
  - Total length is 3 + N/8 bytes.
- FSM states:
  - IDLE -> SYNC on capture.
  - SYNC -> FLAGS, FLAGS -> DATA, on byte accept.
  - DATA stays in DATA while the byte index < N/8-1; it goes to CSUM after the last byte is accepted.
  - CSUM -> IDLE on accept.
- Byte accept = tx_valid && tx_ready at a clk edge.
- Outputs are registered; latency and timing:
  - Capture at edge k; tx_valid=1 with tx_data=SYNC_BYTE from cycle k+1.
  - Each following byte appears in the cycle after the previous byte is accepted.
  - With tx_ready held high, one byte per cycle.
  - Minimum one IDLE cycle (in_ready=1) between frames.
- Backpressure: while tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable. No byte is skipped or duplicated.
- After CSUM is accepted: tx_valid drops in the next cycle, busy=0, in_ready=1.
- tx_ready while tx_valid=0 has no effect.
- The byte index counter is log2-sized for N/8 and wraps to 0 on entering DATA.

Optional Feature:
- Macro: ALU_FRAMER_CSUM_EN.
- Defined: the CSUM byte is appended as above; frame length is 3 + N/8.
- Undefined:
  - The CSUM state and checksum register are not built.
  - DATA goes directly to IDLE after the last RES byte is accepted.
  - Frame length is 2 + N/8.

Test Plan:
- Overflow case: N=16, in_result=16'h9C40, in_flags=5'b10100 (from 20000-(-20000)), tx_ready=1. Required: bytes A5,14,9C,40,C8 on 5 consecutive cycles starting at the cycle after capture. Then tx_valid=0 and in_ready=1.
- Zero result: in_result=16'h0000, in_flags=5'b00011. Required: frame A5,03,00,00,03.
- Backpressure: first case with tx_ready low for 3 cycles while FLAGS is presented. Required: tx_data=8'h14 and tx_valid=1 held for all 3 cycles, then the same 5-byte sequence with no loss or duplication.
- Busy rejection: second word 16'h1234/5'b00001 held on in_valid during a frame. Required: in_ready=0 and no capture until after CSUM. Then captured and emitted as A5,01,12,34,27.
- Reset mid-frame: rst_n low for 1 cycle after the 9C byte is accepted. Required: next cycle tx_valid=0, tx_data=00, busy=0, in_ready=1, and no 40/C8 bytes ever appear.
- Macro undefined: first case yields A5,14,9C,40 only, and tx_valid=0 the cycle after 40 is accepted.
